pipe5_wb_port_arbiter: RTL and testbench

//  Shares the single integer register-file write port between the in-order mem->writeback

---
 rtl/pipe5_wb_port_arbiter_pkg.sv | 21 ++
 rtl/pipe5_wb_port_arbiter_if.sv | 57 +++++
 rtl/pipe5_wb_port_arbiter_wb_result_fifo.sv | 81 ++++++++
 rtl/pipe5_wb_port_arbiter.sv | 107 ++++++++++
 tb/tb_pipe5_wb_port_arbiter.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/pipe5_wb_port_arbiter_pkg.sv
// Shared types for the writeback port arbiter: register index,
// data word and the queued long-latency result entry.
package pipe5_wb_port_arbiter_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_idx_t;

  typedef struct packed {
    reg_idx_t rd;
    word_t    data;
    logic     killed;
  } wb_lu_entry_t;

  localparam int unsigned WB_FIFO_DEPTH   = 2;
  localparam int unsigned WB_STARVE_LIMIT = 3;

  function automatic logic is_x0(input reg_idx_t r);
    return r == '0;
  endfunction

endpackage

// File: rtl/pipe5_wb_port_arbiter_if.sv
// Bundle between writeback stage, long-latency unit and RF port.
// slave = arbiter side, master = pipeline/LU/RF environment side.
interface pipe5_wb_port_arbiter_if
  import pipe5_wb_port_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = WB_FIFO_DEPTH
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          pipe_wen;
  reg_idx_t      pipe_rd;
  word_t         pipe_wdata;
  logic          pipe_stall;

  logic          lu_valid;
  reg_idx_t      lu_rd;
  word_t         lu_wdata;
  logic          lu_ready;

  logic          rf_wen;
  reg_idx_t      rf_waddr;
  word_t         rf_wdata;

  logic [CW-1:0] fifo_count;

  modport slave (
    input  pipe_wen,
    input  pipe_rd,
    input  pipe_wdata,
    output pipe_stall,
    input  lu_valid,
    input  lu_rd,
    input  lu_wdata,
    output lu_ready,
    output rf_wen,
    output rf_waddr,
    output rf_wdata,
    output fifo_count
  );

  modport master (
    output pipe_wen,
    output pipe_rd,
    output pipe_wdata,
    input  pipe_stall,
    output lu_valid,
    output lu_rd,
    output lu_wdata,
    input  lu_ready,
    input  rf_wen,
    input  rf_waddr,
    input  rf_wdata,
    input  fifo_count
  );

endinterface

// File: rtl/pipe5_wb_port_arbiter_wb_result_fifo.sv
// Circular FIFO of LU results with a kill-by-rd port.
// Ports: push/push_entry, pop, kill_en/kill_rd, head, count, empty.
module pipe5_wb_port_arbiter_wb_result_fifo
  import pipe5_wb_port_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = WB_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  wb_lu_entry_t           push_entry,
  input  logic                   pop,
  input  logic                   kill_en,
  input  reg_idx_t               kill_rd,
  output wb_lu_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  wb_lu_entry_t  mem_q [DEPTH];
  wb_lu_entry_t  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    for (int i = 0; i < int'(DEPTH); i++) begin
      if (kill_en && mem_q[i].rd == kill_rd) begin
        mem_d[i].killed = 1'b1;
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      // a write retiring on the same edge still wins
      if (kill_en && push_entry.rd == kill_rd) begin
        mem_d[wr_ptr_q].killed = 1'b1;
      end
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    unique case (1'b1)
      (push && !pop): count_d = count_q + CW'(1);
      (pop && !push): count_d = count_q - CW'(1);
      default:        count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/pipe5_wb_port_arbiter.sv
// Shares the RF write port between writeback and the LU result queue.
// Ports: CLK, nRST, bus (slave): pipe_*, lu_*, rf_*, fifo_count.
module pipe5_wb_port_arbiter
  import pipe5_wb_port_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = WB_FIFO_DEPTH,
  parameter int unsigned STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic                          CLK,
  input  logic                          nRST,
  pipe5_wb_port_arbiter_if.slave        bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  wb_lu_entry_t  head;
  wb_lu_entry_t  push_entry;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          lu_ready;
  logic          push;
  logic          pop;
  logic          kill_en;
  logic          pipe_write;
  logic          live_head;
  logic          lu_grant;
  logic          drains;
  logic [SW-1:0] starve_q, starve_d;

  logic          rf_wen;
  reg_idx_t      rf_waddr;
  word_t         rf_wdata;
  logic          pipe_stall;

  assign full     = (count == FULL_CNT);
  assign lu_ready = (count < FULL_CNT);

  always_comb begin
    pipe_write = bus.pipe_wen && !is_x0(bus.pipe_rd);
    live_head  = !empty && !head.killed;
    lu_grant   = live_head &&
                 (!pipe_write || starve_q >= STARVE_MAX || full);
    pop        = !empty && (head.killed || lu_grant);
    push       = bus.lu_valid && lu_ready;
    // x0 results occupy a slot but never reach the port
    push_entry = '{rd:     bus.lu_rd,
                   data:   bus.lu_wdata,
                   killed: is_x0(bus.lu_rd)};
    // only a retiring pipeline write may kill older LU results
    kill_en    = pipe_write && !lu_grant;
    drains     = pop && !push && (count == CW'(1));

    starve_d = starve_q;
    if (lu_grant || empty || drains) begin
      starve_d = '0;
    end else if (live_head && starve_q < STARVE_MAX) begin
      starve_d = starve_q + SW'(1);
    end

    rf_wen     = pipe_write;
    rf_waddr   = bus.pipe_rd;
    rf_wdata   = bus.pipe_wdata;
    pipe_stall = 1'b0;
    if (lu_grant) begin
      rf_wen     = 1'b1;
      rf_waddr   = head.rd;
      rf_wdata   = head.data;
      pipe_stall = pipe_write;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  pipe5_wb_port_arbiter_wb_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (CLK),
    .rst_n      (nRST),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill_en    (kill_en),
    .kill_rd    (bus.pipe_rd),
    .head       (head),
    .count      (count),
    .empty      (empty)
  );

  assign bus.rf_wen     = rf_wen;
  assign bus.rf_waddr   = rf_waddr;
  assign bus.rf_wdata   = rf_wdata;
  assign bus.pipe_stall = pipe_stall;
  assign bus.lu_ready   = lu_ready;
  assign bus.fifo_count = count;

endmodule

// File: tb/tb_pipe5_wb_port_arbiter.sv
// Directed vector bench for pipe5_wb_port_arbiter.
// Per-cycle table plus reset-mid-traffic sequence and RF model checks.
module tb_pipe5_wb_port_arbiter;
  import pipe5_wb_port_arbiter_pkg::*;

  logic clk;
  logic rst_n;

  pipe5_wb_port_arbiter_if #(.FIFO_DEPTH(2)) bus ();

  pipe5_wb_port_arbiter #(
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (3)
  ) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic     pw;
    reg_idx_t prd;
    word_t    pd;
    logic     lv;
    reg_idx_t lrd;
    word_t    ld;
    logic     ew;
    reg_idx_t ea;
    word_t    ed;
    logic     es;
    logic     er;
    logic [1:0] ec;
  } vec_t;

  vec_t vecs[$];
  int   passed;
  int   total;
  word_t rf_model [32];
  logic x0_hit;

  function automatic vec_t v(
    input logic pw, input int prd, input word_t pd,
    input logic lv, input int lrd, input word_t ld,
    input logic ew, input int ea, input word_t ed,
    input logic es, input logic er, input int ec);
    vec_t r;
    r.pw = pw; r.prd = prd[4:0]; r.pd = pd;
    r.lv = lv; r.lrd = lrd[4:0]; r.ld = ld;
    r.ew = ew; r.ea = ea[4:0]; r.ed = ed;
    r.es = es; r.er = er; r.ec = ec[1:0];
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic drive(input logic pw, input int prd, input word_t pd,
                       input logic lv, input int lrd, input word_t ld);
    bus.pipe_wen   = pw;
    bus.pipe_rd    = prd[4:0];
    bus.pipe_wdata = pd;
    bus.lu_valid   = lv;
    bus.lu_rd      = lrd[4:0];
    bus.lu_wdata   = ld;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rf_wen) begin
      rf_model[bus.rf_waddr] = bus.rf_wdata;
      if (bus.rf_waddr == 5'd0) x0_hit = 1'b1;
    end
  end

  initial begin
    passed = 0;
    total  = 0;
    x0_hit = 1'b0;
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    // idle drain
    vecs.push_back(v(0, 0, 0, 1, 5, 32'hA5A5A5A5, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 5, 32'hA5A5A5A5, 0, 1, 1));
    // starvation
    vecs.push_back(v(1, 1, 32'h101, 1, 7, 32'h777, 1, 1, 32'h101, 0, 1, 0));
    vecs.push_back(v(1, 2, 32'h202, 0, 0, 0, 1, 2, 32'h202, 0, 1, 1));
    vecs.push_back(v(1, 3, 32'h303, 0, 0, 0, 1, 3, 32'h303, 0, 1, 1));
    vecs.push_back(v(1, 4, 32'h404, 0, 0, 0, 1, 4, 32'h404, 0, 1, 1));
    vecs.push_back(v(1, 4, 32'h404, 0, 0, 0, 1, 7, 32'h777, 1, 1, 1));
    vecs.push_back(v(1, 4, 32'h404, 0, 0, 0, 1, 4, 32'h404, 0, 1, 0));
    // full, refused push, stalled write kills nothing
    vecs.push_back(v(1, 10, 32'hA0A, 1, 11, 32'hB0B, 1, 10, 32'hA0A, 0, 1, 0));
    vecs.push_back(v(1, 12, 32'hC0C, 1, 13, 32'hD0D, 1, 12, 32'hC0C, 0, 1, 1));
    vecs.push_back(v(1, 13, 32'hE0E, 1, 15, 32'hF0F, 1, 11, 32'hB0B, 1, 0, 2));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 13, 32'hD0D, 0, 1, 1));
    vecs.push_back(v(1, 13, 32'hE0E, 0, 0, 0, 1, 13, 32'hE0E, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // WAW kill of a queued entry
    vecs.push_back(v(0, 0, 0, 1, 9, 32'h9999, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(1, 9, 32'h1111, 0, 0, 0, 1, 9, 32'h1111, 0, 1, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // WAW kill on the enqueue edge
    vecs.push_back(v(1, 20, 32'h2020, 1, 20, 32'h5555, 1, 20, 32'h2020, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    // x0 on both sides
    vecs.push_back(v(1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 0, 0, 32'hDEAD, 0, 1, 0));
    vecs.push_back(v(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 32'hDEAD, 0, 1, 1));
    vecs.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset.lu_ready", 32'(bus.lu_ready), 32'd1);
    chk("reset.fifo_count", 32'(bus.fifo_count), 32'd0);
    chk("reset.pipe_stall", 32'(bus.pipe_stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].pw, int'(vecs[i].prd), vecs[i].pd,
            vecs[i].lv, int'(vecs[i].lrd), vecs[i].ld);
      @(negedge clk);
      chk($sformatf("v%0d.rf_wen", i), 32'(bus.rf_wen), 32'(vecs[i].ew));
      chk($sformatf("v%0d.rf_waddr", i), 32'(bus.rf_waddr), 32'(vecs[i].ea));
      chk($sformatf("v%0d.rf_wdata", i), bus.rf_wdata, vecs[i].ed);
      chk($sformatf("v%0d.pipe_stall", i), 32'(bus.pipe_stall), 32'(vecs[i].es));
      chk($sformatf("v%0d.lu_ready", i), 32'(bus.lu_ready), 32'(vecs[i].er));
      chk($sformatf("v%0d.fifo_count", i), 32'(bus.fifo_count), 32'(vecs[i].ec));
      @(posedge clk);
      #1;
    end

    chk("rf.x5", rf_model[5], 32'hA5A5A5A5);
    chk("rf.x7", rf_model[7], 32'h777);
    chk("rf.x9", rf_model[9], 32'h1111);
    chk("rf.x11", rf_model[11], 32'hB0B);
    chk("rf.x13", rf_model[13], 32'hE0E);
    chk("rf.x14", rf_model[14], 32'h0);
    chk("rf.x15", rf_model[15], 32'h0);
    chk("rf.x20", rf_model[20], 32'h2020);
    chk("rf.x0_written", 32'(x0_hit), 32'd0);

    // reset while the FIFO is full
    drive(1, 1, 32'h11, 1, 2, 32'h22);
    @(posedge clk);
    #1;
    drive(1, 4, 32'h44, 1, 3, 32'h33);
    @(posedge clk);
    #1;
    chk("midrst.pre_count", 32'(bus.fifo_count), 32'd2);
    chk("midrst.pre_ready", 32'(bus.lu_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.lu_ready", 32'(bus.lu_ready), 32'd1);
    chk("midrst.fifo_count", 32'(bus.fifo_count), 32'd0);
    chk("midrst.pipe_stall", 32'(bus.pipe_stall), 32'd0);
    chk("midrst.rf_waddr", 32'(bus.rf_waddr), 32'd4);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 6, 32'h66, 0, 0, 0);
    @(negedge clk);
    chk("postrst.rf_wen", 32'(bus.rf_wen), 32'd1);
    chk("postrst.rf_waddr", 32'(bus.rf_waddr), 32'd6);
    chk("postrst.rf_wdata", bus.rf_wdata, 32'h66);
    chk("postrst.pipe_stall", 32'(bus.pipe_stall), 32'd0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("postrst.rf_wen_idle", 32'(bus.rf_wen), 32'd0);
    chk("postrst.fifo_count", 32'(bus.fifo_count), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
